jtframe_sdram_upload: RTL and testbench
=======================================

Name: jtframe_sdram_upload

Overview:
- Read-side counterpart of the ROM/NVRAM download path: serves byte reads requested by the MCU during an upload, the reverse of download.
- Converts MCU byte-read strobes (ioctl_addr/ioctl_rd) into 32-bit SDRAM read transactions on the sdram_req/sdram_ack/data_rdy handshake.
- Returns the addressed byte on ioctl_din.
- Keeps a one-line (4-byte) cache so that sequential byte reads cost one SDRAM access per 4 bytes.
- Sits in the clk_rom domain next to the SDRAM controller, in parallel with the download write path.

Parameters:
BANK, 2'd0, SDRAM bank driven on sdram_bank for all upload reads
TIMEOUT, 1023, clk_rom cycles allowed from request issue to data_rdy before the fetch is aborted
OOR_BYTE, 8'hFF, value returned for out-of-range addresses and timed-out fetches

Ports:
clk_rom  in  1  clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
uploading  in  1  upload session active
ioctl_addr  in  25  byte address of the MCU read
ioctl_rd  in  1  one-cycle read strobe
ioctl_din  out  8  returned byte
ioctl_wait  out  1  fetch in progress; MCU holds off
sdram_req  out  1  SDRAM read request
sdram_addr  out  22  16-bit word address
sdram_bank  out  2  constant BANK
sdram_ack  in  1  controller accepted request
data_rdy  in  1  data_read valid, one cycle
data_read  in  32  [15:0] word at sdram_addr, [31:16] word at sdram_addr+1
timeout_err  out  1  sticky: a fetch timed out in this session

Behaviour:
- Reset (async, rst=1): all outputs 0, ioctl_din=0, state IDLE, cache invalid, timeout counter 0.
- A reset mid-fetch drops sdram_req immediately; the controller tolerates this.
- States: IDLE, REQ, WAIT_RDY.
- Line tag: ioctl_addr[22:2]. Byte lane ioctl_addr[1:0] selects from the latched line:
  - 0 -> [7:0]
  - 1 -> [15:8]
  - 2 -> [23:16]
  - 3 -> [31:24]
- ioctl_rd is honoured only in IDLE with uploading=1. Otherwise it is ignored, and ioctl_din and the cache are unchanged.
- Out of range (ioctl_addr[24:23]!=0): ioctl_din=OOR_BYTE on the next edge, no SDRAM access, ioctl_wait stays 0.
- Hit (cache valid, tags equal): ioctl_din updates on the next edge (latency 1), ioctl_wait stays 0.
- Miss:
  - next edge: state REQ, sdram_req=1, sdram_addr={ioctl_addr[22:2],1'b0}, ioctl_wait=1, byte lane stored.
  - REQ: sdram_req held until sdram_ack is sampled 1, then drops on the following edge and state goes to WAIT_RDY.
  - data_rdy is accepted in WAIT_RDY, or in REQ in the same cycle as sdram_ack. data_rdy before ack is ignored.
  - On accepted data_rdy: line <= data_read, tag stored, valid=1, ioctl_din <= selected byte, ioctl_wait=0, state IDLE — all on the same edge.
- Timeout:
  - The counter starts on entry to REQ. On reaching TIMEOUT without accepted data_rdy: sdram_req=0, ioctl_din=OOR_BYTE, ioctl_wait=0, timeout_err=1, cache invalid, state IDLE.
  - A late data_rdy in IDLE is ignored.
- Cache invalidated on any edge of uploading (rising or falling).
- timeout_err clears when uploading rises.
- uploading falls mid-fetch: the SDRAM transaction completes normally, the result is discarded (no cache update), ioctl_din is unchanged, and ioctl_wait drops on completion.
- Simultaneous uploading falling edge and ioctl_rd in IDLE: the read is ignored.
- The SDRAM is never written by this block; sdram_bank is constant BANK from reset.

Decomposition:
- Package jtframe_upload_pkg: state enum (IDLE, REQ, WAIT_RDY), lane-select function (32-bit line, 2-bit lane -> byte), tag width constant (21).
- Single module; no sub-module needed. The timeout counter is 10 bits, sized by $clog2(TIMEOUT+1).

Test Plan:
- Cold miss: uploading=1, rd addr 0x000005, ack 2 cycles later, data_rdy 5 cycles after ack with data_read=0x44332211 -> sdram_addr=0x000002, ioctl_din=0x22 on the data_rdy edge, ioctl_wait high throughout.
- Sequential hits: after the above, rd 0x000004, 0x000006, 0x000007 -> 0x11, 0x33, 0x44, each 1 cycle later, no sdram_req, ioctl_wait=0.
- Line crossing: rd 0x000008 -> new request with sdram_addr=0x000004; a rd pulsed during ioctl_wait is ignored (no second request).
- Out of range: rd 0x0800000 -> ioctl_din=0xFF next cycle, sdram_req never asserted.
- Timeout: ack given, data_rdy withheld 1100 cycles -> at cycle 1023 ioctl_din=0xFF, timeout_err=1, ioctl_wait=0; a late data_rdy leaves state and cache unchanged; timeout_err clears on the next uploading rise.
- Session edges: uploading falls mid-fetch -> fetch completes, ioctl_din unchanged. Uploading re-rises, rd 0x000004 -> miss (new request). rst asserted mid-REQ -> sdram_req, ioctl_wait, ioctl_din all 0 asynchronously.

Source files
------------

// File: rtl/jtframe_upload_pkg.sv
// Shared types and helpers for the SDRAM upload (read-back) path.
package jtframe_upload_pkg;

  localparam int TAG_W = 21;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RDY = 2'd2
  } state_e;

  function automatic logic [7:0] lane_sel(input logic [31:0] line, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = line[7:0];
      2'd1:    b = line[15:8];
      2'd2:    b = line[23:16];
      default: b = line[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jtframe_sdram_upload_if.sv
// MCU read strobe side and SDRAM read handshake side of the upload block.
interface jtframe_sdram_upload_if;
  logic        uploading;
  logic [24:0] ioctl_addr;
  logic        ioctl_rd;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic [1:0]  sdram_bank;
  logic        sdram_ack;
  logic        data_rdy;
  logic [31:0] data_read;
  logic        timeout_err;

  modport master (
    output uploading, ioctl_addr, ioctl_rd, sdram_ack, data_rdy, data_read,
    input  ioctl_din, ioctl_wait, sdram_req, sdram_addr, sdram_bank, timeout_err
  );

  modport slave (
    input  uploading, ioctl_addr, ioctl_rd, sdram_ack, data_rdy, data_read,
    output ioctl_din, ioctl_wait, sdram_req, sdram_addr, sdram_bank, timeout_err
  );
endinterface

// File: rtl/jtframe_sdram_upload.sv
// Serves MCU byte reads during upload from SDRAM through a one-line (4-byte) cache,
// with a bounded wait on the SDRAM read handshake.
module jtframe_sdram_upload
  import jtframe_upload_pkg::*;
#(
  parameter logic [1:0] BANK     = 2'd0,
  parameter int         TIMEOUT  = 1023,
  parameter logic [7:0] OOR_BYTE = 8'hFF
)(
  input  logic            clk_rom,
  input  logic            rst,
  jtframe_sdram_upload_if.slave bus
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [31:0]        line_q, line_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               valid_q, valid_d;
  logic [1:0]         lane_q, lane_d;
  logic [7:0]         din_q, din_d;
  logic               wait_q, wait_d;
  logic               req_q, req_d;
  logic [21:0]        addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               terr_q, terr_d;
  logic               upl_q, upl_d;
  logic               discard_q, discard_d;

  logic             up_rise, up_fall, up_edge;
  logic [TAG_W-1:0] rd_tag;
  logic             oor, hit, rdy_ok, discard_now;

  assign up_rise     = bus.uploading & ~upl_q;
  assign up_fall     = ~bus.uploading & upl_q;
  assign up_edge     = up_rise | up_fall;
  assign rd_tag      = bus.ioctl_addr[22:2];
  assign oor         = |bus.ioctl_addr[24:23];
  // A session edge invalidates the line on this same edge, so it cannot hit.
  assign hit         = valid_q & ~up_edge & (tag_q == rd_tag);
  assign rdy_ok      = bus.data_rdy & ((state_q == WAIT_RDY) | ((state_q == REQ) & bus.sdram_ack));
  assign discard_now = discard_q | up_fall;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path can infer a latch.
    state_d   = state_q;
    line_d    = line_q;
    tag_d     = tag_q;
    valid_d   = valid_q;
    lane_d    = lane_q;
    din_d     = din_q;
    wait_d    = wait_q;
    req_d     = req_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    terr_d    = terr_q & ~up_rise;
    upl_d     = bus.uploading;
    discard_d = discard_q;

    unique case (state_q)
      IDLE: begin
        if (bus.ioctl_rd && bus.uploading) begin
          if (oor) begin
            din_d = OOR_BYTE;
          end else if (hit) begin
            din_d = lane_sel(line_q, bus.ioctl_addr[1:0]);
          end else begin
            state_d   = REQ;
            req_d     = 1'b1;
            wait_d    = 1'b1;
            addr_d    = {rd_tag, 1'b0};
            lane_d    = bus.ioctl_addr[1:0];
            tag_d     = rd_tag;
            valid_d   = 1'b0;
            cnt_d     = '0;
            discard_d = 1'b0;
          end
        end
      end
      REQ, WAIT_RDY: begin
        if (rdy_ok) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wait_d  = 1'b0;
          // A session that ended mid-fetch still lets the SDRAM finish, but drops the data.
          if (!discard_now) begin
            line_d  = bus.data_read;
            valid_d = 1'b1;
            din_d   = lane_sel(bus.data_read, lane_q);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          wait_d  = 1'b0;
          din_d   = OOR_BYTE;
          terr_d  = 1'b1;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (state_q == REQ && bus.sdram_ack) begin
            req_d   = 1'b0;
            state_d = WAIT_RDY;
          end
        end
        if (up_fall) discard_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (up_edge) valid_d = 1'b0;
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_rom or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      line_q    <= '0;
      tag_q     <= '0;
      valid_q   <= 1'b0;
      lane_q    <= '0;
      din_q     <= '0;
      wait_q    <= 1'b0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
      terr_q    <= 1'b0;
      upl_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      lane_q    <= lane_d;
      din_q     <= din_d;
      wait_q    <= wait_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
      upl_q     <= upl_d;
      discard_q <= discard_d;
    end
  end

  assign bus.ioctl_din   = din_q;
  assign bus.ioctl_wait  = wait_q;
  assign bus.sdram_req   = req_q;
  assign bus.sdram_addr  = addr_q;
  assign bus.sdram_bank  = BANK;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_jtframe_sdram_upload.sv
// Self-checking bench for jtframe_sdram_upload: vector table, corner sequences, random reads.
module tb_jtframe_sdram_upload;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  jtframe_sdram_upload_if bus();

  jtframe_sdram_upload #(
    .BANK     (2'd0),
    .TIMEOUT  (1023),
    .OOR_BYTE (8'hFF)
  ) dut (
    .clk_rom (clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [24:0] addr;
    logic [31:0] data;
    logic [7:0]  exp_din;
    bit          exp_miss;
    logic [21:0] exp_saddr;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Byte-level view of SDRAM contents used by the random phase.
  function automatic logic [7:0] mem_byte(input logic [24:0] a);
    logic [31:0] x;
    x = 32'(a) * 32'h9E3779B1;
    return x[31:24] ^ x[7:0];
  endfunction

  // One MCU read; if a request appears, acks after ack_dly cycles and returns data rdy_dly after ack.
  task automatic read_txn(input logic [24:0] addr, input logic [31:0] data,
                          input int ack_dly, input int rdy_dly,
                          output logic [7:0] din, output bit saw_req,
                          output logic [21:0] req_addr, output bit wait_ok);
    bus.ioctl_addr = addr;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    saw_req  = bus.sdram_req;
    req_addr = bus.sdram_addr;
    wait_ok  = (bus.ioctl_wait == saw_req);
    if (saw_req) begin
      for (int i = 0; i < ack_dly; i++) begin
        tick();
        wait_ok = wait_ok & bus.ioctl_wait & bus.sdram_req;
      end
      bus.sdram_ack = 1'b1;
      if (rdy_dly == 0) begin
        bus.data_rdy  = 1'b1;
        bus.data_read = data;
      end
      tick();
      bus.sdram_ack = 1'b0;
      bus.data_rdy  = 1'b0;
      if (rdy_dly > 0) begin
        wait_ok = wait_ok & bus.ioctl_wait & ~bus.sdram_req;
        for (int i = 1; i < rdy_dly; i++) begin
          tick();
          wait_ok = wait_ok & bus.ioctl_wait;
        end
        bus.data_rdy  = 1'b1;
        bus.data_read = data;
        tick();
        bus.data_rdy = 1'b0;
      end
      wait_ok = wait_ok & ~bus.ioctl_wait;
    end
    din = bus.ioctl_din;
  endtask

  initial begin
    logic [7:0]  din;
    bit          saw_req, wait_ok;
    logic [21:0] req_addr;
    int          to_cycle;
    bit          stray_req;
    bit          model_valid;
    logic [22:0] model_tag;
    logic [24:0] addr;
    logic [24:0] base;
    logic [31:0] line;
    bit          exp_miss;
    logic [22:0] bases[4];

    vecs[0]  = '{25'h0000005, 32'h44332211, 8'h22, 1'b1, 22'h000002};
    vecs[1]  = '{25'h0000004, 32'h0,        8'h11, 1'b0, 22'h0};
    vecs[2]  = '{25'h0000006, 32'h0,        8'h33, 1'b0, 22'h0};
    vecs[3]  = '{25'h0000007, 32'h0,        8'h44, 1'b0, 22'h0};
    vecs[4]  = '{25'h0000008, 32'h88776655, 8'h55, 1'b1, 22'h000004};
    vecs[5]  = '{25'h000000B, 32'h0,        8'h88, 1'b0, 22'h0};
    vecs[6]  = '{25'h0800000, 32'h0,        8'hFF, 1'b0, 22'h0};
    vecs[7]  = '{25'h0000009, 32'h0,        8'h66, 1'b0, 22'h0};
    vecs[8]  = '{25'h1FFFFFF, 32'h0,        8'hFF, 1'b0, 22'h0};
    vecs[9]  = '{25'h07FFFFC, 32'hDDCCBBAA, 8'hAA, 1'b1, 22'h3FFFFE};
    vecs[10] = '{25'h07FFFFF, 32'h0,        8'hDD, 1'b0, 22'h0};
    vecs[11] = '{25'h0000004, 32'h44332211, 8'h11, 1'b1, 22'h000002};

    bus.uploading  = 1'b1;
    bus.ioctl_addr = '0;
    bus.ioctl_rd   = 1'b0;
    bus.sdram_ack  = 1'b0;
    bus.data_rdy   = 1'b0;
    bus.data_read  = '0;

    // Reset state
    repeat (2) tick();
    check("rst_din",  32'(bus.ioctl_din), 32'h0);
    check("rst_wait", 32'(bus.ioctl_wait), 32'h0);
    check("rst_req",  32'(bus.sdram_req), 32'h0);
    check("rst_addr", 32'(bus.sdram_addr), 32'h0);
    check("rst_terr", 32'(bus.timeout_err), 32'h0);
    check("rst_bank", 32'(bus.sdram_bank), 32'h0);
    rst = 1'b0;
    tick();

    // Vector table: cold miss, sequential hits, line crossing, out-of-range, top of range
    for (int i = 0; i < 12; i++) begin
      read_txn(vecs[i].addr, vecs[i].data, 2, 5, din, saw_req, req_addr, wait_ok);
      check($sformatf("vec%0d_din", i), 32'(din), 32'(vecs[i].exp_din));
      check($sformatf("vec%0d_req", i), 32'(saw_req), 32'(vecs[i].exp_miss));
      check($sformatf("vec%0d_wait", i), 32'(wait_ok), 32'h1);
      if (vecs[i].exp_miss)
        check($sformatf("vec%0d_saddr", i), 32'(req_addr), 32'(vecs[i].exp_saddr));
    end

    // Read strobe during a fetch is ignored
    bus.ioctl_addr = 25'h10;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_addr = 25'h20;
    check("busy_req", 32'(bus.sdram_req), 32'h1);
    tick();
    bus.ioctl_rd  = 1'b0;
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'hCAFEF00D;
    tick();
    bus.data_rdy = 1'b0;
    check("busy_din", 32'(bus.ioctl_din), 32'h0D);
    check("busy_saddr", 32'(bus.sdram_addr), 32'h8);
    stray_req = 1'b0;
    repeat (4) begin
      tick();
      stray_req = stray_req | bus.sdram_req;
    end
    check("busy_no_second_req", 32'(stray_req), 32'h0);

    // Timeout after ack with data_rdy withheld
    bus.ioctl_addr = 25'h30;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("to_req", 32'(bus.sdram_req), 32'h1);
    to_cycle = 0;
    for (int k = 1; k <= 1100; k++) begin
      if (k == 1) bus.sdram_ack = 1'b1;
      tick();
      bus.sdram_ack = 1'b0;
      if (!bus.ioctl_wait) begin
        to_cycle = k;
        break;
      end
    end
    check("to_cycle", 32'(to_cycle), 32'd1023);
    check("to_din",  32'(bus.ioctl_din), 32'hFF);
    check("to_terr", 32'(bus.timeout_err), 32'h1);
    check("to_req_low", 32'(bus.sdram_req), 32'h0);
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'h12345678;
    tick();
    bus.data_rdy = 1'b0;
    check("late_rdy_din",  32'(bus.ioctl_din), 32'hFF);
    check("late_rdy_wait", 32'(bus.ioctl_wait), 32'h0);
    read_txn(25'h30, 32'h9988776A, 1, 3, din, saw_req, req_addr, wait_ok);
    check("after_to_miss", 32'(saw_req), 32'h1);
    check("after_to_din",  32'(din), 32'h6A);
    check("terr_sticky",   32'(bus.timeout_err), 32'h1);
    bus.uploading = 1'b0;
    tick();
    check("terr_hold_on_fall", 32'(bus.timeout_err), 32'h1);
    bus.uploading = 1'b1;
    tick();
    check("terr_clear_on_rise", 32'(bus.timeout_err), 32'h0);

    // Session ends mid-fetch: completes, result discarded
    read_txn(25'h4, 32'h44332211, 1, 2, din, saw_req, req_addr, wait_ok);
    check("sess_pre_din", 32'(din), 32'h11);
    bus.ioctl_addr = 25'h40;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd  = 1'b0;
    bus.uploading = 1'b0;
    tick();
    bus.sdram_ack = 1'b1;
    tick();
    bus.sdram_ack = 1'b0;
    bus.data_rdy  = 1'b1;
    bus.data_read = 32'hAABBCCDD;
    tick();
    bus.data_rdy = 1'b0;
    check("sess_fall_din",  32'(bus.ioctl_din), 32'h11);
    check("sess_fall_wait", 32'(bus.ioctl_wait), 32'h0);
    // Read on the same edge uploading falls
    bus.uploading = 1'b1;
    tick();
    bus.uploading  = 1'b0;
    bus.ioctl_addr = 25'h5;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("fall_rd_ignored_req", 32'(bus.sdram_req), 32'h0);
    check("fall_rd_ignored_din", 32'(bus.ioctl_din), 32'h11);
    bus.uploading = 1'b1;
    tick();
    read_txn(25'h4, 32'h44332255, 0, 1, din, saw_req, req_addr, wait_ok);
    check("rerise_miss", 32'(saw_req), 32'h1);
    check("rerise_din",  32'(din), 32'h55);

    // Asynchronous reset during REQ
    bus.ioctl_addr = 25'h100;
    bus.ioctl_rd   = 1'b1;
    tick();
    bus.ioctl_rd = 1'b0;
    check("arst_pre_req", 32'(bus.sdram_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_req",  32'(bus.sdram_req), 32'h0);
    check("arst_wait", 32'(bus.ioctl_wait), 32'h0);
    check("arst_din",  32'(bus.ioctl_din), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Random reads against a byte-level memory and cache model
    bases[0] = 23'h000000;
    bases[1] = 23'h001000;
    bases[2] = 23'h7FFFF0;
    bases[3] = 23'h123450;
    model_valid = 1'b0;
    model_tag   = '0;
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0)
        addr = {2'($urandom_range(1, 3)), 23'($urandom)};
      else
        addr = {2'b00, bases[$urandom_range(0, 3)] + 23'($urandom_range(0, 15))};
      base = {addr[24:2], 2'b00};
      line = {mem_byte(base + 25'd3), mem_byte(base + 25'd2), mem_byte(base + 25'd1), mem_byte(base)};
      read_txn(addr, line, $urandom_range(0, 3), $urandom_range(0, 4), din, saw_req, req_addr, wait_ok);
      if (addr[24:23] != 2'b00) begin
        exp_miss = 1'b0;
        check("rnd_oor_din", 32'(din), 32'hFF);
      end else begin
        exp_miss = !(model_valid && model_tag == addr[24:2]);
        check("rnd_din", 32'(din), 32'(mem_byte(addr)));
        model_valid = 1'b1;
        model_tag   = addr[24:2];
      end
      check("rnd_req", 32'(saw_req), 32'(exp_miss));
      check("rnd_wait", 32'(wait_ok), 32'h1);
      if (exp_miss)
        check("rnd_saddr", 32'(req_addr), 32'(addr[22:2]) << 1);
    end
    check("final_bank", 32'(bus.sdram_bank), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
